// File: rtl/buffer_pkg.sv
// Shared width constants for the 512-to-64 width-converting buffer.
package buffer_pkg;
    localparam int unsigned IN_W  = 512;
    localparam int unsigned OUT_W = 64;
    localparam int unsigned RATIO = IN_W / OUT_W;
    localparam int unsigned IDX_W = $clog2(RATIO);
endpackage

// File: rtl/buffer_mem.sv
// Entry storage: one synchronous write port, one asynchronous read port, no reset.
module buffer_mem #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned WIDTH  = 512,
    parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/buffer_512_to_64.sv
// Width-converting FWFT FIFO: 512-bit entries in, eight 64-bit words out, LS word first.
module buffer_512_to_64
    import buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned IN_W  = 512,
    parameter int unsigned OUT_W = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [IN_W-1:0]  data_in,
    input  logic             wr_enable,
    output logic [OUT_W-1:0] data_out,
    input  logic             rd_enable,
    output logic             full,
    output logic             empty,
    output logic             full_n
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [IDX_W-1:0] idx;
    logic [CNT_W-1:0] count;
    logic [IN_W-1:0]  head_entry;
    logic             do_wr;
    logic             do_rd;
    logic             entry_done;
    logic             mem_we;

    assign empty  = (count == '0);
    assign full   = (count == CNT_W'(DEPTH));
    assign full_n = ~full;

    // Flags come from the pre-edge count, so a read freeing an entry cannot admit a same-cycle write.
    assign do_wr      = wr_enable & ~full;
    assign do_rd      = rd_enable & ~empty;
    assign entry_done = do_rd & (idx == IDX_W'(RATIO - 1));
    assign mem_we     = do_wr & ~rst & ~clr;

    buffer_mem #(
        .DEPTH (DEPTH),
        .WIDTH (IN_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (head_entry)
    );

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            idx    <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // idx is exactly IDX_W bits wide, so it wraps to 0 after the last word by itself.
            if (do_rd) begin
                idx <= idx + 1'b1;
            end
            if (entry_done) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_wr, entry_done})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        if (!empty) begin
            data_out = head_entry[idx*OUT_W +: OUT_W];
        end
    end

endmodule

// File: tb/tb_buffer_512_to_64.sv
// Scoreboard bench for buffer_512_to_64: word-queue reference model, directed then random traffic.
module tb_buffer_512_to_64;

    localparam int unsigned DEPTH = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         clr;
    logic [511:0] data_in;
    logic         wr_enable;
    logic [63:0]  data_out;
    logic         rd_enable;
    logic         full;
    logic         empty;
    logic         full_n;

    logic [63:0]  exp_q[$];
    bit           mon_en = 1'b0;
    int unsigned  checks = 0;
    int unsigned  failures = 0;

    buffer_512_to_64 #(
        .DEPTH (DEPTH),
        .IN_W  (512),
        .OUT_W (64)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .data_in   (data_in),
        .wr_enable (wr_enable),
        .data_out  (data_out),
        .rd_enable (rd_enable),
        .full      (full),
        .empty     (empty),
        .full_n    (full_n)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h expected=%h", name, $time, act, exp);
        end
    endfunction

    function automatic logic [511:0] seq_entry(int unsigned base);
        logic [511:0] e;
        for (int k = 0; k < 8; k++) e[64*k +: 64] = 64'(base + k + 1);
        return e;
    endfunction

    function automatic logic [511:0] rand_entry();
        logic [511:0] e;
        for (int i = 0; i < 16; i++) e[32*i +: 32] = $urandom;
        return e;
    endfunction

    // Model: a buffered entry occupies a slot until its last word leaves, hence ceil(words/8).
    function automatic int unsigned model_entries();
        return (exp_q.size() + 7) / 8;
    endfunction

    // One clock: apply inputs, decide acceptance from the pre-edge model, push expected words at the edge.
    task automatic step(input bit w, input logic [511:0] d, input bit r, input bit c, input bit rs);
        bit wr_ok;
        wr_enable = w;
        data_in   = d;
        rd_enable = r;
        clr       = c;
        rst       = rs;
        wr_ok = w && !c && !rs && (model_entries() < DEPTH);
        @(posedge clk);
        if (rs || c) begin
            exp_q.delete();
        end else if (wr_ok) begin
            for (int k = 0; k < 8; k++) exp_q.push_back(d[64*k +: 64]);
        end
        if (rs) mon_en = 1'b1;
        #1;
    endtask

    task automatic write_entry(input logic [511:0] d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic read_n(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: mid-cycle, compare flags and head word against the model, pop on a consuming read.
    always @(negedge clk) begin
        if (mon_en) begin
            chk("empty", 64'(empty), 64'(exp_q.size() == 0));
            chk("full", 64'(full), 64'(model_entries() == DEPTH));
            chk("full_n", 64'(full_n), 64'(model_entries() != DEPTH));
            if (exp_q.size() == 0) begin
                chk("data_out_empty", data_out, 64'd0);
            end else begin
                chk("data_out", data_out, exp_q[0]);
                if (rd_enable && !clr && !rst) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        rst = 1'b1; clr = 1'b0; wr_enable = 1'b0; rd_enable = 1'b0; data_in = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with read pulses that must do nothing.
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        step(1'b1, seq_entry(0), 1'b1, 1'b0, 1'b1);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);

        // Three sequential entries, full drain, then 10 reads past empty.
        write_entry(seq_entry(0));
        write_entry(seq_entry(8));
        write_entry(seq_entry(16));
        read_n(24);
        read_n(10);
        write_entry(seq_entry(0));
        read_n(8);

        // Overflow: fifth write dropped; one entry freed admits the next write.
        for (int unsigned e = 0; e < 5; e++) write_entry(seq_entry(100 + 8*e));
        read_n(8);
        write_entry(seq_entry(200));
        read_n(36);

        // Simultaneous write and read of the last word of the only entry.
        write_entry(seq_entry(300));
        read_n(7);
        step(1'b1, seq_entry(400), 1'b1, 1'b0, 1'b0);
        read_n(10);

        // Clear mid-stream, then a fresh entry reads back cleanly.
        write_entry(seq_entry(500));
        write_entry(seq_entry(600));
        read_n(3);
        step(1'b1, seq_entry(700), 1'b1, 1'b1, 1'b0);
        write_entry(seq_entry(0));
        read_n(10);

        // Random traffic with occasional clears.
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), rand_entry(), 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 63) == 0), 1'b0);
        end

        // Reset while loaded, then drain.
        write_entry(rand_entry());
        step(1'b0, '0, 1'b1, 1'b0, 1'b1);
        write_entry(rand_entry());
        read_n(45);
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffer_512_to_64.md
Name: buffer_512_to_64

Overview:
Width-converting FIFO. It accepts 512-bit entries on a write port and returns them as eight consecutive 64-bit words on a read port. Within each entry the least-significant word comes out first. It sits between a wide producer (e.g. a 512-bit bus or cipher block stream) and a 64-bit consumer. The read side is first-word-fall-through: data_out always presents the word at the head of the buffer.

Parameters:
DEPTH, 4, number of 512-bit entries stored (power of two, >=2)
IN_W, 512, input entry width (fixed; must equal 8*OUT_W)
OUT_W, 64, output word width (fixed)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, synchronous, active-high
clr  input  1  synchronous clear of buffer contents/pointers, active-high
data_in  input  512  entry to write; word k = data_in[64k+63:64k]
wr_enable  input  1  write request, sampled at rising edge
data_out  output  64  head word (FWFT); 0 when empty
rd_enable  input  1  read/pop request for current head word
full  output  1  no free 512-bit entry; writes ignored
empty  output  1  no 64-bit word available; reads ignored
full_n  output  1  always ~full

Behaviour:
- State: entry storage mem[DEPTH], write pointer, read pointer, 3-bit word index within the head entry, entry count 0..DEPTH.
- Reset (rst=1 at rising edge): pointers, word index and count go to 0. After reset: empty=1, full=0, full_n=1, data_out=0. Memory contents need not be reset. rst has priority over clr and over all requests.
- clr=1 (rst=0): same effect as reset on the next edge. Pending wr_enable/rd_enable in that cycle are ignored.
- Write: wr_enable=1 and full=0 at the edge -> mem[wr_ptr]<=data_in, wr_ptr++ (wrap at DEPTH), count++. wr_enable while full is dropped silently, with no state change.
- Read: rd_enable=1 and empty=0 at the edge -> the word on data_out is consumed. The word index increments. When the index is 7, it wraps to 0, rd_ptr++ (wrap) and count--. rd_enable while empty is ignored.
- data_out = mem[rd_ptr][64*idx +: 64] when count>0, else 0. It is combinational from registers and valid in the same cycle that empty=0.
- Write latency: an entry written at edge N makes empty=0 and data_out=word0 right after edge N.
- Flags are derived from registered count: empty=(count==0), full=(count==DEPTH).
- Simultaneous write and read in one cycle: both take effect. If the read frees the last word of an entry, count is net unchanged.
- A write when full is rejected even if the same-cycle read frees an entry; full is evaluated before the edge.
- Each 512-bit entry is held until all 8 words are read; partial entries are never overwritten.
- Holding rd_enable high continuously drains one word per cycle until empty, then idles with no underflow.

Decomposition:
- Package buffer_pkg: constants IN_W=512, OUT_W=64, RATIO=IN_W/OUT_W=8, IDX_W=$clog2(RATIO).
- The top module holds the pointer/count control and the output word mux.
- A natural sub-module is a simple dual-port register array, buffer_mem (DEPTH x 512, one write port, one async read port).

Test Plan:
- Reset: hold rst=1 for 2 cycles -> empty=1, full=0, full_n=1, data_out=0. rd_enable pulses have no effect.
- Write three entries {8..1}, {16..9}, {24..17}, with word k of entry e = 8e+k+1 -> after first write, data_out=1 and empty=0. Then hold rd_enable for 24 cycles -> data_out sequence 1,2,...,24, one per cycle, then empty=1 and data_out=0.
- Overflow: write DEPTH=4 entries -> full=1, full_n=0. A 5th write is ignored. Read 8 words -> full=0, and the next write is accepted. Read all remaining words -> original order with no corruption.
- Underflow: rd_enable held 10 extra cycles after the 24th word -> empty stays 1, count stays 0. A subsequent write of {64'd8..64'd1} -> data_out=1.
- Simultaneous: with 1 entry buffered and index=7, assert wr_enable and rd_enable together -> the next head is word0 of the new entry, count stays 1, empty=0.
- clr mid-stream: after 3 words read of a 2-entry buffer, pulse clr -> empty=1, data_out=0. A new write of {64'd8..64'd1} then reads back 1..8.
